// File: rtl/mem_dump.sv
// Memory dump engine: reads a contiguous word region through the mem load port
// and streams it out over valid/ready with a running 32-bit checksum.
module mem_dump #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_start,
    input  logic [63:0] io_baseAddr,
    input  logic [15:0] io_wordCount,
    output logic        io_busy,
    output logic        io_done,
    output logic [63:0] io_mem_dataAddr,
    output logic        io_mem_writeEn,
    output logic [31:0] io_mem_writeData,
    output logic [2:0]  io_mem_func3,
    input  logic [31:0] io_mem_lsu_data,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_data,
    output logic        io_out_last,
    output logic [31:0] io_checksum
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [63:0] base_q, base_d;
    logic [63:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] csum_q, csum_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;

    logic [PW:0]  occ;
    logic         empty, full, pop, issue, final_rd, start_ok, drain_empty;
    logic [63:0]  rd_addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occ         = wr_ptr_q - rd_ptr_q;
    assign empty       = (occ == '0);
    assign full        = (occ == (PW+1)'(FIFO_DEPTH));
    assign pop         = !empty && io_out_ready;
    assign start_ok    = io_start && (state_q == S_IDLE);
    assign issue       = (state_q == S_READ) && (idx_q < count_q) && (!full || pop);
    assign final_rd    = issue && (idx_q == count_q - 16'd1);
    assign rd_addr     = base_q + {46'd0, idx_q, 2'b00};
    assign drain_empty = empty || ((occ == (PW+1)'(1)) && pop);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        csum_d   = csum_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (io_wordCount == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (final_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            idx_d    = idx_q + 16'd1;
            addr_d   = rd_addr;
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
            csum_d   = csum_q + fifo_data_q[rd_ptr_q[PW-1:0]];
        end
        if (start_ok) begin
            base_d   = io_baseAddr & ~64'h3;
            count_d  = io_wordCount;
            idx_d    = '0;
            addr_d   = '0;
            csum_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            csum_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            csum_q   <= csum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; outputs are masked by empty so stale entries never leak.
    always_ff @(posedge clock) begin
        if (issue) begin
            fifo_data_q[wr_ptr_q[PW-1:0]] <= io_mem_lsu_data;
            fifo_last_q[wr_ptr_q[PW-1:0]] <= final_rd;
        end
    end

    assign io_busy          = (state_q == S_READ) || (state_q == S_DRAIN);
    assign io_done          = (state_q == S_DONE);
    assign io_mem_dataAddr  = (state_q == S_READ) ? (issue ? rd_addr : addr_q) : 64'd0;
    assign io_mem_writeEn   = 1'b0;
    assign io_mem_writeData = 32'd0;
    assign io_mem_func3     = 3'b010;
    assign io_out_valid     = !empty;
    assign io_out_data      = empty ? 32'd0 : fifo_data_q[rd_ptr_q[PW-1:0]];
    assign io_out_last      = !empty && fifo_last_q[rd_ptr_q[PW-1:0]];
    assign io_checksum      = csum_q;

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: directed dumps plus randomized base/count/ready.
module tb_mem_dump;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_start;
    logic [63:0] io_baseAddr;
    logic [15:0] io_wordCount;
    logic        io_busy;
    logic        io_done;
    logic [63:0] io_mem_dataAddr;
    logic        io_mem_writeEn;
    logic [31:0] io_mem_writeData;
    logic [2:0]  io_mem_func3;
    logic [31:0] io_mem_lsu_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_data;
    logic        io_out_last;
    logic [31:0] io_checksum;

    int errors = 0;
    int checks = 0;
    int cyc;
    logic [31:0] last_sum;

    always #5 clock = ~clock;

    mem_dump #(.FIFO_DEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_start         (io_start),
        .io_baseAddr      (io_baseAddr),
        .io_wordCount     (io_wordCount),
        .io_busy          (io_busy),
        .io_done          (io_done),
        .io_mem_dataAddr  (io_mem_dataAddr),
        .io_mem_writeEn   (io_mem_writeEn),
        .io_mem_writeData (io_mem_writeData),
        .io_mem_func3     (io_mem_func3),
        .io_mem_lsu_data  (io_mem_lsu_data),
        .io_out_valid     (io_out_valid),
        .io_out_ready     (io_out_ready),
        .io_out_data      (io_out_data),
        .io_out_last      (io_out_last),
        .io_checksum      (io_checksum)
    );

    // Memory image: preload words at 0x100..0x10C, a fixed hash of the address elsewhere.
    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a >= 64'h100 && a < 64'h110)
            return 32'h11111111 * ({30'd0, a[3:2]} + 32'd1);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endfunction

    assign io_mem_lsu_data = memf(io_mem_dataAddr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready, 3 ready low for cycles 1..6
    task automatic dump(input logic [63:0] base, input logic [15:0] cnt, input int mode,
                        input int repulse);
        logic [63:0] ab;
        logic [31:0] exp_q[$];
        logic [31:0] sum;
        logic        r, pv, pr, pl, seen_done;
        logic [31:0] pd;
        ab = base & ~64'h3;
        exp_q.delete();
        for (int k = 0; k < int'(cnt); k++) exp_q.push_back(memf(ab + 64'(k) * 64'd4));
        io_baseAddr  = base;
        io_wordCount = cnt;
        io_start     = 1'b1;
        cyc          = 0;
        step();
        io_start  = 1'b0;
        sum       = '0;
        pv        = 1'b0;
        pr        = 1'b0;
        pl        = 1'b0;
        pd        = '0;
        seen_done = 1'b0;
        while (cyc < 1000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc - 1) % 3) == 0;
                2:       r = $urandom_range(0, 1) == 1;
                default: r = cyc > 6;
            endcase
            io_out_ready = r;
            if (cyc == repulse) begin
                io_start     = 1'b1;
                io_baseAddr  = ~base;
                io_wordCount = cnt + 16'd3;
            end else begin
                io_start = 1'b0;
            end
            check("checksum_run", io_checksum, sum);
            if (io_done) begin
                seen_done = 1'b1;
                if (mode == 0) check("done_cycle", cyc, (cnt == 0) ? 1 : int'(cnt) + 2);
                check("done_valid", io_out_valid, 0);
                check("done_busy", io_busy, 0);
                break;
            end
            check("busy", io_busy, 1);
            if (mode == 0 && cyc <= int'(cnt))
                check("addr_seq", io_mem_dataAddr, ab + 64'(cyc - 1) * 64'd4);
            if (mode == 3 && cnt >= 5 && (cyc == 5 || cyc == 6))
                check("addr_stall", io_mem_dataAddr, ab + 64'd12);
            if (pv && !pr) begin
                check("stall_valid", io_out_valid, 1);
                check("stall_data", io_out_data, pd);
                check("stall_last", io_out_last, pl);
            end
            if (io_out_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    check("out_data", io_out_data, exp_q[0]);
                    check("out_last", io_out_last, exp_q.size() == 1);
                    sum = sum + exp_q[0];
                    void'(exp_q.pop_front());
                end
            end
            pv = io_out_valid;
            pr = r;
            pd = io_out_data;
            pl = io_out_last;
            step();
        end
        io_start = 1'b0;
        if (!seen_done) check("timeout_done", 0, 1);
        check("words_left", exp_q.size(), 0);
        step();
        check("post_checksum", io_checksum, sum);
        check("post_done", io_done, 0);
        check("post_busy", io_busy, 0);
        check("post_addr", io_mem_dataAddr, 0);
        last_sum = sum;
    endtask

    initial begin
        reset        = 1'b0;
        io_start     = 1'b0;
        io_baseAddr  = '0;
        io_wordCount = '0;
        io_out_ready = 1'b0;
        cyc          = 0;
        #1;
        check("rst_busy", io_busy, 0);
        check("rst_done", io_done, 0);
        check("rst_valid", io_out_valid, 0);
        check("rst_addr", io_mem_dataAddr, 0);
        check("rst_func3", io_mem_func3, 3'b010);
        check("rst_wen", io_mem_writeEn, 0);
        check("rst_wdata", io_mem_writeData, 0);
        check("rst_csum", io_checksum, 0);
        step();
        step();
        reset = 1'b1;
        step();

        dump(64'h100, 16'd4, 0, -1);
        check("csum_preload", last_sum, 32'hAAAAAAAA);
        dump(64'h100, 16'd4, 1, -1);
        check("csum_toggle", last_sum, 32'hAAAAAAAA);
        dump(64'h100, 16'd0, 0, -1);
        dump(64'h103, 16'd2, 0, -1);
        dump(64'hFFFF_FFFF_FFFF_FFFC, 16'd2, 0, -1);
        dump(64'h4000, 16'd9, 3, -1);
        dump(64'h100, 16'd4, 0, 2);
        check("csum_repulse", last_sum, 32'hAAAAAAAA);

        // Reset in the middle of a dump.
        io_baseAddr  = 64'h2000;
        io_wordCount = 16'd8;
        io_start     = 1'b1;
        io_out_ready = 1'b0;
        step();
        io_start = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", io_busy, 0);
        check("mid_rst_done", io_done, 0);
        check("mid_rst_valid", io_out_valid, 0);
        check("mid_rst_data", io_out_data, 0);
        check("mid_rst_last", io_out_last, 0);
        check("mid_rst_addr", io_mem_dataAddr, 0);
        check("mid_rst_csum", io_checksum, 0);
        step();
        check("mid_rst_hold_done", io_done, 0);
        reset = 1'b1;
        step();
        check("after_rst_done", io_done, 0);
        dump(64'h100, 16'd4, 0, -1);
        check("csum_after_rst", last_sum, 32'hAAAAAAAA);

        for (int t = 0; t < 8; t++) begin
            logic [63:0] rb;
            rb = {$urandom, $urandom};
            if (t == 0) rb = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            dump(rb, 16'($urandom_range(0, 20)), 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dump.md
# mem_dump

Memory dump engine for the RV32I test harness. It is the read-side counterpart to the boot-time image load. After a program finishes, it takes over the data port of `mem` and reads a contiguous word region through the normal load path (`dataAddr`, `func3`, `lsu_data`). It streams the words out over a valid/ready interface and keeps a running checksum, so benches can compare signature regions against golden data.

## Interface
- `FIFO_DEPTH`, 4: depth of the read-data buffer (power of two, ≥2).
- `clock` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-low reset.
- `io_start` in 1: one-cycle request to begin a dump; ignored while `io_busy`.
- `io_baseAddr` in 64: byte address of the first word, sampled on accepted start; bits [1:0] forced to 0.
- `io_wordCount` in 16: number of 32-bit words to dump, sampled on accepted start.
- `io_busy` out 1: dump in progress; also selects this block as master of the `mem` data port.
- `io_done` out 1: one-cycle pulse when a dump completes.
- `io_mem_dataAddr` out 64: read address to `mem`.
- `io_mem_writeEn` out 1: tied 0; the block never writes.
- `io_mem_writeData` out 32: tied 0.
- `io_mem_func3` out 3: constant 3'b010 (LW).
- `io_mem_lsu_data` in 32: `mem` load data, combinational from `io_mem_dataAddr`.
- `io_out_valid` out 1, `io_out_ready` in 1, `io_out_data` out 32, `io_out_last` out 1: dump stream.
- `io_checksum` out 32: sum mod 2^32 of all words accepted on the stream since the last accepted start.

## Operation
- States:
  - IDLE: start with count>0 → READ; start with count==0 → DONE.
  - READ: stays in READ until the final read is issued, then → DRAIN.
  - DRAIN: → DONE when the FIFO is empty.
  - DONE: → IDLE after one cycle.
- Accepted start:
  - Latch the aligned base and the count.
  - Clear the index `i`, the checksum and the FIFO.
- READ issue:
  - A read is issued in a cycle when `i < count` and the FIFO is not full.
  - `io_mem_dataAddr = base + 4*i`, computed in 64 bits and wrapping modulo 2^64.
  - `lsu_data` is written into the FIFO at the end of the same cycle, and `i` increments.
  - When no read is issued, the address is held at its last value.
  - Outside READ the address is 0.
- Stream:
  - `io_out_valid` = FIFO non-empty; `io_out_data` = FIFO head.
  - A transfer occurs when valid && ready; the entry is popped and `io_checksum += data`.
  - `io_out_last` is high with the entry that is read index count-1.
  - Valid, data and last must stay stable while ready is low.
- The FIFO accepts a push and a pop in the same cycle, including when full; a pop frees the slot, so a push still proceeds.
- `io_busy` = state ≠ IDLE and state ≠ DONE.
- `io_done` = state == DONE.
- `io_start` is ignored in READ, DRAIN and DONE.

## Timing
- Reset values (asynchronous assertion, synchronous release on the next edge):
  - state IDLE; all outputs 0; `io_mem_func3` = 3'b010.
  - FIFO empty; `io_checksum` 0.
- Start sampled at edge 0: READ from cycle 1, first read issued in cycle 1, `io_out_valid` first high in cycle 2.
- With ready held high, throughput is 1 word/cycle. For N words:
  - Reads occur in cycles 1..N.
  - Transfers occur in cycles 2..N+1.
  - `io_done` is high in cycle N+2, and `io_busy` is low from cycle N+2.
- Start with count 0: `io_done` in cycle 1, no valid and no memory access.
- Backpressure:
  - Reads stall while the FIFO is full.
  - No word may be lost or duplicated; output order equals address order.
- Reset asserted mid-dump:
  - Immediate return to IDLE; FIFO flushed; `io_busy` 0.
  - No `io_done` pulse.
- Checksum holds its final value after DONE until the next accepted start.

## Test plan
- Preload `mem` words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x100; start with base 0x100, count 4, ready=1:
  - Stream carries those words in order in cycles 2..5, last high in cycle 5.
  - `io_done` in cycle 6; checksum 0xAAAAAAAA.
- Same dump with ready toggling 1,0,0,1,...:
  - Identical word sequence and checksum; valid, data and last stable while stalled.
  - Reads pause after 4 issued with no pops.
- Start with count 0: `io_done` in cycle 1; `io_out_valid` never high; `io_busy` never high.
- Base 0x103, count 2: addresses driven are 0x100, 0x104.
- Base 0xFFFF_FFFF_FFFF_FFFC, count 2: addresses 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- `io_start` re-pulsed mid-dump is ignored. Reset asserted mid-dump: all outputs 0 immediately; a new start afterward runs cleanly with checksum from 0.
